iod_dly_ctrl: RTL

Sequencer and arbiter for one IOD dynamic delay line (LPDDR3 PHY lanes such as ODT, DQ, CA). Two fabric requesters (0 = write-leveling/training, 1 = periodic tracking) share the line's MOVE/DIRECTION/LOAD controls. The block grants one command at a time and expands a step count into paced single-cycle MOVE pulses with settle gaps. It stops on the IOD's out-of-range flag and reports status.

---
 rtl/iod_dly_pkg.sv | 21 ++
 rtl/iod_dly_ctrl_if.sv | 22 ++
 rtl/iod_dly_rr_arb.sv | 30 +++
 rtl/iod_dly_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/iod_dly_pkg.sv
// Shared types for the IOD dynamic delay-line sequencer: FSM states, latched command, requester count.
package iod_dly_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_LOAD,
      ST_MOVE,
      ST_WAIT,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic       load;
      logic       dir;
      logic [7:0] steps;
   } cmd_t;

endpackage

// File: rtl/iod_dly_ctrl_if.sv
// Requester-side command handshake of the delay-line sequencer (level REQ, one-cycle GNT/DONE).
interface iod_dly_ctrl_if;
   import iod_dly_pkg::*;

   logic [NUM_REQ-1:0]   REQ;
   logic [NUM_REQ-1:0]   REQ_LOAD;
   logic [NUM_REQ-1:0]   REQ_DIR;
   logic [8*NUM_REQ-1:0] REQ_STEPS;
   logic [NUM_REQ-1:0]   GNT;
   logic [NUM_REQ-1:0]   DONE;

   modport master (
      output REQ, REQ_LOAD, REQ_DIR, REQ_STEPS,
      input  GNT, DONE
   );

   modport slave (
      input  REQ, REQ_LOAD, REQ_DIR, REQ_STEPS,
      output GNT, DONE
   );

endinterface

// File: rtl/iod_dly_rr_arb.sv
// 2-way round-robin arbiter; the last-grant pointer moves only when adv is asserted.
module iod_dly_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic       win_vld,
   output logic       win_idx
);

   logic last_q;
   logic last_d;

   // A lone requester wins outright; on a tie the one not granted last wins.
   always_comb begin
      win_vld = |req;
      win_idx = (req == 2'b11) ? ~last_q : req[1];
      last_d  = adv ? win_idx : last_q;
   end

   // Reset as if requester 1 was granted last, so requester 0 is favoured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/iod_dly_ctrl.sv
// Arbitrates two requesters onto one IOD delay line and paces MOVE/LOAD pulses with settle gaps.
// Optional soft tap tracking and limit pre-check: define IOD_DLY_CTRL_TAP_TRACK_EN.
module iod_dly_ctrl
   import iod_dly_pkg::*;
#(
   parameter int SETTLE   = 4,
   parameter int LOAD_TAP = 1,
   parameter int TAP_MAX  = 255
) (
   input  logic           FAB_CLK,
   input  logic           ARST,
   iod_dly_ctrl_if.slave  req_if,
   output logic [7:0]     STEPS_DONE,
   output logic           OOR_STICKY,
   output logic [7:0]     TAP_CNT,
   output logic           DELAY_LINE_MOVE,
   output logic           DELAY_LINE_DIRECTION,
   output logic           DELAY_LINE_LOAD,
   input  logic           DELAY_LINE_OUT_OF_RANGE
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

   if (SETTLE < 1 || TAP_MAX < 1 || TAP_MAX > 255 || LOAD_TAP < 0 || LOAD_TAP > TAP_MAX)
   begin : g_bad_param
      $error("iod_dly_ctrl: illegal parameter set");
   end

   state_t             state_q, state_d;
   cmd_t               cmd_q, cmd_d;
   logic               owner_q, owner_d;
   logic [7:0]         rem_q, rem_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               move_q, move_d;
   logic               load_q, load_d;
   logic               oor_q, oor_d;
   logic [7:0]         steps_done_q, steps_done_d;

   logic               arb_vld;
   logic               arb_idx;
   logic               arb_adv;
   logic               want_move;
   logic               finish;
   logic [7:0]         rem_cur;
   logic               move_ok;

`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
   localparam logic [7:0] LOAD_TAP_V = 8'(LOAD_TAP);
   localparam logic [7:0] TAP_MAX_V  = 8'(TAP_MAX);

   logic [7:0] tap_q, tap_d;

   assign move_ok = cmd_q.dir ? (tap_q < TAP_MAX_V) : (tap_q != 8'd0);
   assign TAP_CNT = tap_q;
`else
   assign move_ok = 1'b1;
   assign TAP_CNT = '0;
`endif

   iod_dly_rr_arb u_arb (
      .clk     (FAB_CLK),
      .rst     (ARST),
      .req     (req_if.REQ),
      .adv     (arb_adv),
      .win_vld (arb_vld),
      .win_idx (arb_idx)
   );

   // Outputs are computed for the state being entered, so they are flops aligned with it.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      owner_d      = owner_q;
      rem_d        = rem_q;
      cnt_d        = cnt_q;
      gnt_d        = '0;
      done_d       = '0;
      move_d       = 1'b0;
      load_d       = 1'b0;
      oor_d        = oor_q;
      steps_done_d = steps_done_q;
      arb_adv      = 1'b0;
      want_move    = 1'b0;
      finish       = 1'b0;
      rem_cur      = rem_q;
`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
      tap_d        = tap_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               arb_adv        = 1'b1;
               owner_d        = arb_idx;
               cmd_d.load     = req_if.REQ_LOAD[arb_idx];
               cmd_d.dir      = req_if.REQ_DIR[arb_idx];
               cmd_d.steps    = arb_idx ? req_if.REQ_STEPS[15:8] : req_if.REQ_STEPS[7:0];
               gnt_d[arb_idx] = 1'b1;
               steps_done_d   = '0;
               state_d        = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (cmd_q.load) begin
               load_d  = 1'b1;
               oor_d   = 1'b0;
`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
               tap_d   = LOAD_TAP_V;
`endif
               state_d = ST_LOAD;
            end else if (cmd_q.steps == 8'd0) begin
               finish = 1'b1;
            end else begin
               want_move = 1'b1;
               rem_cur   = cmd_q.steps;
            end
         end
         ST_LOAD, ST_MOVE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == SETTLE_LAST) begin
               if (DELAY_LINE_OUT_OF_RANGE) begin
                  oor_d  = 1'b1;
                  finish = 1'b1;
               end else if (rem_q == 8'd0 || cmd_q.load) begin
                  finish = 1'b1;
               end else begin
                  want_move = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Soft-limit check happens before the pulse, so a refused move never reaches the IOD.
      if (want_move) begin
         if (move_ok) begin
            move_d       = 1'b1;
            rem_d        = rem_cur - 8'd1;
            steps_done_d = steps_done_q + 8'd1;
`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
            tap_d        = cmd_q.dir ? tap_q + 8'd1 : tap_q - 8'd1;
`endif
            state_d      = ST_MOVE;
         end else begin
            oor_d  = 1'b1;
            finish = 1'b1;
         end
      end

      if (finish) begin
         done_d[owner_q] = 1'b1;
         state_d         = ST_DONE;
      end
   end

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         owner_q      <= 1'b0;
         rem_q        <= '0;
         cnt_q        <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         move_q       <= 1'b0;
         load_q       <= 1'b0;
         oor_q        <= 1'b0;
         steps_done_q <= '0;
`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
         tap_q        <= LOAD_TAP_V;
`endif
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         owner_q      <= owner_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         move_q       <= move_d;
         load_q       <= load_d;
         oor_q        <= oor_d;
         steps_done_q <= steps_done_d;
`ifdef IOD_DLY_CTRL_TAP_TRACK_EN
         tap_q        <= tap_d;
`endif
      end
   end

   assign req_if.GNT           = gnt_q;
   assign req_if.DONE          = done_q;
   assign STEPS_DONE           = steps_done_q;
   assign OOR_STICKY           = oor_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_DIRECTION = cmd_q.dir;

endmodule
